// File: rtl/vga_pix_pkg.sv
// Shared definitions for the VGA sprite pixel generator.
// Holds the register-map offsets, pixel/sprite sizes and CTRL bit positions
// used by the Wishbone register block and the pixel pipeline.
package vga_pix_pkg;

  localparam int RGB_W      = 8;
  localparam int SPR_SIZE   = 16;
  localparam int SPR_IDX_W  = $clog2(SPR_SIZE);
  localparam logic [SPR_IDX_W-1:0] SPR_IDX_MAX = SPR_IDX_W'(SPR_SIZE - 1);

  // Register offsets within the 256-byte window (adr[7:0]).
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_BG       = 8'h04;
  localparam logic [7:0] REG_POS      = 8'h08;
  localparam logic [7:0] REG_SCOL     = 8'h0C;
  localparam logic [7:0] REG_FRAME    = 8'h10;
  localparam logic [7:0] REG_STATUS   = 8'h14;
  localparam logic [7:0] REG_BMP_BASE = 8'h40;

  // CTRL register bit indices.
  localparam int CTRL_W         = 2;
  localparam int CTRL_SPRITE_EN = 0;
  localparam int CTRL_TEST_MODE = 1;

endpackage

// File: rtl/vga_pix_wb_regs.sv
// Wishbone configuration slave for the sprite pixel generator.
// Decodes a 256-byte window at BASE_ADDR, returns a single-cycle registered
// ack, keeps pending (bus-visible) and active (pixel-visible) copies of
// CTRL/BG/POS/SCOL, the single-buffered 16x16 sprite bitmap and a frame
// counter. Active copies and the counter advance on the frame edge (first
// cycle v_sync reaches VSYNC_ACTIVE).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cyc, stb, we, adr, dat     Wishbone request
//   dout, ack                  Wishbone response (dout is 0 outside ack)
//   v_sync                     raw v_sync from the timing controller
//   sprite_en, test_mode, bg, scol, spr_x, spr_y   active configuration
//   bmp                        sprite rows, bmp[row][15] is the leftmost pixel
module vga_pix_wb_regs
  import vga_pix_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0100,
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter int          COORD_W      = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cyc,
  input  logic                                stb,
  input  logic                                we,
  input  logic [31:0]                         adr,
  input  logic [31:0]                         dat,
  output logic [31:0]                         dout,
  output logic                                ack,
  input  logic                                v_sync,
  output logic                                sprite_en,
  output logic                                test_mode,
  output logic [RGB_W-1:0]                    bg,
  output logic [RGB_W-1:0]                    scol,
  output logic [COORD_W-1:0]                  spr_x,
  output logic [COORD_W-1:0]                  spr_y,
  output logic [SPR_SIZE-1:0][SPR_SIZE-1:0]   bmp
);

  logic                 sel;
  logic                 wr_en;
  logic [7:0]           offset;
  logic                 is_bmp;
  logic [SPR_IDX_W-1:0] bmp_idx;
  logic                 vs_act;
  logic                 vs_act_q;
  logic                 frame_edge;
  logic [31:0]          rdata;
  logic [15:0]          frame_cnt;
  logic                 unused_dat;

  logic [CTRL_W-1:0]    ctrl_pend;
  logic [RGB_W-1:0]     bg_pend;
  logic [RGB_W-1:0]     scol_pend;
  logic [COORD_W-1:0]   x_pend;
  logic [COORD_W-1:0]   y_pend;

  assign sel     = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]);
  // The request is still held while ack is high, so the write lands then.
  assign wr_en   = sel & we & ack;
  assign offset  = adr[7:0];
  assign is_bmp  = (offset[7:6] == REG_BMP_BASE[7:6]) && (offset[1:0] == 2'b00);
  assign bmp_idx = offset[SPR_IDX_W+1:2];

  assign vs_act     = (v_sync == VSYNC_ACTIVE);
  assign frame_edge = vs_act & ~vs_act_q;

  // Not every data bit maps to a register field.
  assign unused_dat = ^dat;

  always_comb begin
    rdata = '0;
    if (is_bmp) begin
      rdata[SPR_SIZE-1:0] = bmp[bmp_idx];
    end else begin
      case (offset)
        REG_CTRL:   rdata[CTRL_W-1:0]   = ctrl_pend;
        REG_BG:     rdata[RGB_W-1:0]    = bg_pend;
        REG_POS: begin
          rdata[COORD_W-1:0]  = x_pend;
          rdata[16 +: COORD_W] = y_pend;
        end
        REG_SCOL:   rdata[RGB_W-1:0]    = scol_pend;
        REG_FRAME:  rdata[15:0]         = frame_cnt;
        REG_STATUS: rdata[0]            = vs_act;
        default:    rdata               = '0;
      endcase
    end
  end

  // Bus handshake: ack never repeats back-to-back, dout only valid with ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      dout <= '0;
    end else begin
      ack  <= sel & ~ack;
      dout <= (sel & ~ack) ? rdata : '0;
    end
  end

  // Starting as "already active" keeps a low v_sync at reset release from
  // being counted as a frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_q  <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_act_q <= vs_act;
      if (frame_edge) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Pending copies and bitmap take bus writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_pend <= '0;
      bg_pend   <= '0;
      scol_pend <= '0;
      x_pend    <= '0;
      y_pend    <= '0;
      bmp       <= '0;
    end else if (wr_en) begin
      if (is_bmp) begin
        bmp[bmp_idx] <= dat[SPR_SIZE-1:0];
      end else begin
        case (offset)
          REG_CTRL: ctrl_pend <= dat[CTRL_W-1:0];
          REG_BG:   bg_pend   <= dat[RGB_W-1:0];
          REG_POS: begin
            x_pend <= dat[COORD_W-1:0];
            y_pend <= dat[16 +: COORD_W];
          end
          REG_SCOL: scol_pend <= dat[RGB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Active copies sample the pending values as they stood before any write
  // committing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_en <= 1'b0;
      test_mode <= 1'b0;
      bg        <= '0;
      scol      <= '0;
      spr_x     <= '0;
      spr_y     <= '0;
    end else if (frame_edge) begin
      sprite_en <= ctrl_pend[CTRL_SPRITE_EN];
      test_mode <= ctrl_pend[CTRL_TEST_MODE];
      bg        <= bg_pend;
      scol      <= scol_pend;
      spr_x     <= x_pend;
      spr_y     <= y_pend;
    end
  end

endmodule

// File: rtl/vga_sprite_pixel_gen.sv
// VGA sprite pixel generator: turns the timing controller's row/column/
// display_enable/syncs into RGB332 pixels (background, one 16x16 monochrome
// sprite, or an XOR test pattern). Two-stage pipeline; syncs and DE are
// delayed alongside so everything leaves together two cycles after input.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cyc, stb, we, adr, dat     Wishbone request
//   dout, ack                  Wishbone response
//   row, column                current pixel position
//   display_enable, h_sync, v_sync   timing controller qualifiers
//   rgb                        pixel {R[2:0],G[2:0],B[1:0]}
//   h_sync_o, v_sync_o, de_o   syncs/DE aligned with rgb
module vga_sprite_pixel_gen
  import vga_pix_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0100,
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter int          COORD_W      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cyc,
  input  logic               stb,
  input  logic               we,
  input  logic [31:0]        adr,
  input  logic [31:0]        dat,
  output logic [31:0]        dout,
  output logic               ack,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] column,
  input  logic               display_enable,
  input  logic               h_sync,
  input  logic               v_sync,
  output logic [RGB_W-1:0]   rgb,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic               de_o
);

  logic                              sprite_en;
  logic                              test_mode;
  logic [RGB_W-1:0]                  bg;
  logic [RGB_W-1:0]                  scol;
  logic [COORD_W-1:0]                spr_x;
  logic [COORD_W-1:0]                spr_y;
  logic [SPR_SIZE-1:0][SPR_SIZE-1:0] bmp;

  logic [COORD_W-1:0]   dx;
  logic [COORD_W-1:0]   dy;
  logic                 hit;

  logic                 de_p1, hs_p1, vs_p1, hit_p1;
  logic [SPR_IDX_W-1:0] dx_p1, dy_p1;
  logic [RGB_W-1:0]     col_p1, row_p1;
  logic                 pix_bit;

  function automatic logic [RGB_W-1:0] pix_colour(
    input logic             de,
    input logic             tm,
    input logic             spr,
    input logic [RGB_W-1:0] pattern,
    input logic [RGB_W-1:0] bg_c,
    input logic [RGB_W-1:0] scol_c
  );
    if (!de)     return '0;
    else if (tm) return pattern;
    else if (spr) return scol_c;
    return bg_c;
  endfunction

  vga_pix_wb_regs #(
    .BASE_ADDR    (BASE_ADDR),
    .VSYNC_ACTIVE (VSYNC_ACTIVE),
    .COORD_W      (COORD_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .cyc       (cyc),
    .stb       (stb),
    .we        (we),
    .adr       (adr),
    .dat       (dat),
    .dout      (dout),
    .ack       (ack),
    .v_sync    (v_sync),
    .sprite_en (sprite_en),
    .test_mode (test_mode),
    .bg        (bg),
    .scol      (scol),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .bmp       (bmp)
  );

  // Modulo subtraction: pixels left of / above the sprite wrap to large
  // offsets and fall outside the 16x16 window.
  assign dx  = column - spr_x;
  assign dy  = row - spr_y;
  assign hit = sprite_en & (dx < COORD_W'(SPR_SIZE)) & (dy < COORD_W'(SPR_SIZE));

  // ---- stage 1: sprite window test, capture qualifiers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      hit_p1 <= 1'b0;
      dx_p1  <= '0;
      dy_p1  <= '0;
      col_p1 <= '0;
      row_p1 <= '0;
    end else begin
      de_p1  <= display_enable;
      hs_p1  <= h_sync;
      vs_p1  <= v_sync;
      hit_p1 <= hit;
      dx_p1  <= dx[SPR_IDX_W-1:0];
      dy_p1  <= dy[SPR_IDX_W-1:0];
      col_p1 <= column[RGB_W-1:0];
      row_p1 <= row[RGB_W-1:0];
    end
  end

  // MSB of each bitmap row is the leftmost pixel.
  assign pix_bit = bmp[dy_p1][SPR_IDX_MAX - dx_p1];

  // ---- stage 2: colour select, aligned sync/DE outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb      <= '0;
      h_sync_o <= 1'b0;
      v_sync_o <= 1'b0;
      de_o     <= 1'b0;
    end else begin
      rgb      <= pix_colour(de_p1, test_mode, hit_p1 & pix_bit,
                             col_p1 ^ row_p1, bg, scol);
      h_sync_o <= hs_p1;
      v_sync_o <= vs_p1;
      de_o     <= de_p1;
    end
  end

endmodule

// File: tb/tb_vga_sprite_pixel_gen.sv
// Directed bench for vga_sprite_pixel_gen with a pixel scoreboard: each
// driven pixel pushes its expected {rgb,h_sync_o,v_sync_o,de_o} with the
// cycle it is due; the tick task pops and compares due entries.
module tb_vga_sprite_pixel_gen;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [31:0] dout;
  logic        ack;
  logic [11:0] row, column;
  logic        display_enable, h_sync, v_sync;
  logic [7:0]  rgb;
  logic        h_sync_o, v_sync_o, de_o;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [10:0] exp_q[$];
  int          due_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  vga_sprite_pixel_gen #(
    .BASE_ADDR    (BASE),
    .VSYNC_ACTIVE (1'b0),
    .COORD_W      (12)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cyc            (cyc),
    .stb            (stb),
    .we             (we),
    .adr            (adr),
    .dat            (dat),
    .dout           (dout),
    .ack            (ack),
    .row            (row),
    .column         (column),
    .display_enable (display_enable),
    .h_sync         (h_sync),
    .v_sync         (v_sync),
    .rgb            (rgb),
    .h_sync_o       (h_sync_o),
    .v_sync_o       (v_sync_o),
    .de_o           (de_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    while (due_q.size() > 0 && due_q[0] <= cyc_n) begin
      logic [10:0] e;
      string       t;
      int          d;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      d = due_q.pop_front();
      chk(t, {21'b0, rgb, h_sync_o, v_sync_o, de_o}, {21'b0, e});
    end
  endtask

  task automatic idle(input int n);
    display_enable = 1'b0;
    h_sync = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input logic [11:0] c, input logic [11:0] r, input logic d,
                     input logic hs, input logic [7:0] exp, input string tag);
    column = c;
    row = r;
    display_enable = d;
    h_sync = hs;
    exp_q.push_back({exp, hs, v_sync, d});
    due_q.push_back(cyc_n + 2);
    tag_q.push_back(tag);
    tick();
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic edge_at_commit, input logic chk_rd,
                         input logic [31:0] exp_rd, input string tag);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    chk({tag, " ack_before"}, {31'b0, ack}, 32'd0);
    tick();
    chk({tag, " ack"}, {31'b0, ack}, 32'd1);
    if (chk_rd) chk({tag, " dout"}, dout, exp_rd);
    if (edge_at_commit) v_sync = 1'b0;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (edge_at_commit) v_sync = 1'b1;
    chk({tag, " ack_single"}, {31'b0, ack}, 32'd0);
    if (chk_rd) chk({tag, " dout_idle"}, dout, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    wb_xfer(1'b1, a, d, 1'b0, 1'b0, 32'd0, tag);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    wb_xfer(1'b0, a, 32'd0, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic frame_edge();
    v_sync = 1'b0;
    tick();
    v_sync = 1'b1;
    tick();
  endtask

  initial begin
    // Reset held while inputs toggle.
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; dat = 32'hFFFF_FFFF;
    row = 12'h00F; column = 12'h0F5; display_enable = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      h_sync = ~h_sync;
      v_sync = ~v_sync;
      column = column + 12'd1;
      we = ~we;
      tick();
      chk("reset rgb", {24'b0, rgb}, 32'd0);
      chk("reset ack", {31'b0, ack}, 32'd0);
      chk("reset dout", dout, 32'd0);
      chk("reset syncs", {29'b0, h_sync_o, v_sync_o, de_o}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; v_sync = 1'b1; h_sync = 1'b1; display_enable = 1'b0;
    rst_n = 1'b1;
    tick();
    wb_read(BASE + 32'h10, 32'd0, "frame after reset");

    // Bus basics.
    wb_write(BASE + 32'h04, 32'h0000_00E0, "wr bg");
    wb_read(BASE + 32'h04, 32'h0000_00E0, "rd bg");
    wb_read(BASE + 32'h20, 32'd0, "rd unmapped");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4000_0000;
    tick();
    chk("foreign adr ack1", {31'b0, ack}, 32'd0);
    tick();
    chk("foreign adr ack2", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;

    // Double buffering of BG.
    pix(12'd5, 12'd5, 1'b1, 1'b1, 8'h00, "bg before edge");
    idle(2);
    frame_edge();
    pix(12'd5, 12'd5, 1'b1, 1'b1, 8'hE0, "bg after edge");
    pix(12'd6, 12'd5, 1'b0, 1'b1, 8'h00, "bg de low");
    idle(2);
    wb_write(BASE + 32'h04, 32'h0000_001C, "wr bg 1c");
    pix(12'd7, 12'd5, 1'b1, 1'b1, 8'hE0, "bg held midframe");
    idle(2);
    frame_edge();
    pix(12'd7, 12'd5, 1'b1, 1'b1, 8'h1C, "bg new frame");
    idle(2);
    wb_xfer(1'b1, BASE + 32'h04, 32'h0000_0055, 1'b1, 1'b0, 32'd0, "wr bg on edge");
    pix(12'd8, 12'd5, 1'b1, 1'b1, 8'h1C, "bg edge write deferred");
    idle(2);
    frame_edge();
    pix(12'd8, 12'd5, 1'b1, 1'b1, 8'h55, "bg edge write next frame");
    idle(2);

    // Frame counter and status.
    wb_read(BASE + 32'h10, 32'd4, "frame count");
    wb_read(BASE + 32'h14, 32'd0, "status inactive");
    v_sync = 1'b0;
    wb_read(BASE + 32'h14, 32'd1, "status active");
    v_sync = 1'b1;
    tick();
    wb_read(BASE + 32'h10, 32'd5, "frame count status");

    // Sprite.
    wb_write(BASE + 32'h40, 32'h0000_8001, "wr bmp0");
    wb_write(BASE + 32'h08, (32'd50 << 16) | 32'd100, "wr pos");
    wb_write(BASE + 32'h0C, 32'h0000_00FF, "wr scol");
    wb_write(BASE + 32'h04, 32'h0000_0003, "wr bg 03");
    wb_write(BASE + 32'h00, 32'h0000_0001, "wr ctrl");
    wb_read(BASE + 32'h08, (32'd50 << 16) | 32'd100, "rd pos");
    wb_read(BASE + 32'h40, 32'h0000_8001, "rd bmp0");
    frame_edge();
    pix(12'd100, 12'd50, 1'b1, 1'b1, 8'hFF, "spr left edge");
    pix(12'd115, 12'd50, 1'b1, 1'b1, 8'hFF, "spr right edge");
    pix(12'd101, 12'd50, 1'b1, 1'b1, 8'h03, "spr clear bit");
    pix(12'd99,  12'd50, 1'b1, 1'b1, 8'h03, "spr left of x");
    pix(12'd116, 12'd50, 1'b1, 1'b1, 8'h03, "spr right of box");
    pix(12'd100, 12'd51, 1'b1, 1'b1, 8'h03, "spr row1 empty");
    pix(12'd100, 12'd49, 1'b1, 1'b1, 8'h03, "spr above y");
    idle(3);

    // Test mode overrides the sprite; sync alignment.
    wb_write(BASE + 32'h00, 32'h0000_0003, "wr ctrl test");
    frame_edge();
    pix(12'h0F5, 12'h00F, 1'b1, 1'b0, 8'hFA, "test xor hs0");
    pix(12'h0F5, 12'h00F, 1'b1, 1'b1, 8'hFA, "test xor hs1");
    pix(12'd100, 12'd50, 1'b1, 1'b0, 8'h56, "test over sprite");
    pix(12'h0F5, 12'h00F, 1'b0, 1'b1, 8'h00, "test de low");
    pix(12'h0F5, 12'h00F, 1'b1, 1'b0, 8'hFA, "test hs toggle");
    idle(3);

    // Frame counter wrap.
    force dut.u_regs.frame_cnt = 16'hFFFF;
    #1;
    release dut.u_regs.frame_cnt;
    wb_read(BASE + 32'h10, 32'h0000_FFFF, "frame preload");
    frame_edge();
    wb_read(BASE + 32'h10, 32'd0, "frame wrap");

    // Reset in the middle of active video.
    pix(12'h0F5, 12'h00F, 1'b1, 1'b1, 8'hFA, "pre reset pixel");
    tick();
    rst_n = 1'b0;
    #1;
    chk("midreset rgb", {24'b0, rgb}, 32'd0);
    chk("midreset de", {31'b0, de_o}, 32'd0);
    tick();
    chk("midreset hold", {24'b0, rgb, h_sync_o, v_sync_o, de_o} , 32'd0);
    rst_n = 1'b1;
    pix(12'h0F5, 12'h00F, 1'b1, 1'b1, 8'h00, "first pixel after reset");
    idle(3);
    wb_read(BASE + 32'h00, 32'd0, "ctrl after reset");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
